cache_port_scheduler: RTL and testbench
=======================================

CACHE_PORT_SCHEDULER -- requirements
Module: cache_port_scheduler

Interface
REQ-001 SHALL have parameter CLR_PERIOD, default 1024: cycles between reference-bit clear sweeps, legal range 300..65535.
REQ-002 SHALL have parameter NSETS, default 256: number of cache sets swept, indexed by rc_set.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports rN_req, input, 1 (N=0,1): requester N access request, level.
REQ-006 SHALL have ports rN_op, input, 1: 0=read, 1=write.
REQ-007 SHALL have ports rN_addr and rN_wdata, input, 32 each: byte address and write data.
REQ-008 SHALL have ports rN_gnt, output, 1: one-cycle pulse marking acceptance of the request.
REQ-009 SHALL have ports rN_done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports rN_rdata, output, 32: read data, valid while rN_done=1.
REQ-011 SHALL have ports c_req (output, 1), c_op (output, 1), c_addr (output, 32) and c_wdata (output, 32): cache command.
REQ-012 SHALL have ports c_ack (input, 1) and c_rdata (input, 32): cache completion and read data.
REQ-013 SHALL have ports rc_en (output, 1) and rc_set (output, 8): ref-bit clear strobe and set index.
REQ-014 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCESS, DONE and SWEEP.
REQ-016 IDLE selection order SHALL be: sweep_pending first, then a single requesting port, then round-robin on both.
REQ-017 When both ports request, the port not granted last SHALL win; after reset, r0 wins the first tie.
REQ-018 On the edge leaving IDLE for ACCESS, rN_op, rN_addr and rN_wdata SHALL be latched; the requester may deassert or change them after rN_gnt.
REQ-019 In the first ACCESS cycle, rN_gnt SHALL pulse and c_req SHALL rise.
REQ-020 c_req, c_op, c_addr and c_wdata SHALL stay stable until the edge at which c_ack=1 is sampled; a c_ack in the first ACCESS cycle is legal.
REQ-021 c_ack sampled outside ACCESS SHALL be ignored.
REQ-022 After ACCESS, DONE SHALL last one cycle with rN_done=1 for the granted port only.
REQ-023 In DONE, rN_rdata SHALL carry the registered c_rdata for reads and 0 for writes; it SHALL hold until the next done.
REQ-024 After DONE, the state SHALL return to IDLE; minimum latency is req seen at edge k -> gnt in cycle k+1 -> done in cycle k+2 -> IDLE in cycle k+3.
REQ-025 The period counter SHALL count every cycle, wrap at CLR_PERIOD-1 and set sweep_pending on wrap.
REQ-026 A wrap occurring while sweep_pending=1 or in SWEEP SHALL be dropped, never queued.
REQ-027 SWEEP SHALL never interrupt ACCESS or DONE; it is entered only from IDLE.
REQ-028 In SWEEP, rc_en=1 for exactly NSETS consecutive cycles with rc_set=0,1,...,NSETS-1.
REQ-029 sweep_pending SHALL clear on SWEEP entry, and SWEEP SHALL return to IDLE after set NSETS-1.
REQ-030 In SWEEP, c_req SHALL be 0 and requests SHALL wait with no gnt.
REQ-031 No more than one of rc_en, c_req and any rN_done SHALL be high in any cycle.
REQ-032 A request deasserted before grant SHALL be dropped silently.

Reset
REQ-033 While rst=1 at an edge, state SHALL go to IDLE and every output SHALL be 0, including rN_rdata, c_addr, c_wdata and rc_set.
REQ-034 Reset SHALL clear the period counter and sweep_pending and set round-robin priority to r0.
REQ-035 Reset during ACCESS SHALL abandon the transaction with no rN_done; c_req SHALL be 0 in the cycle after the reset edge.

Verification
REQ-036 Single read: r0 read to addr 64 with c_ack in the first ACCESS cycle and c_rdata=111 -> r0_gnt in cycle k+1, r0_done with r0_rdata=111 in cycle k+2, busy low in k+3.
REQ-037 Contention: r0 and r1 request continuously after reset -> grants alternate r0,r1,r0,r1 with c_addr matching each granted port.
REQ-038 Write with slow cache: r1 write to addr 2112 with data 5000 and c_ack delayed 5 cycles -> c_req, c_op=1, c_addr=2112 and c_wdata=5000 held 6 cycles; r1_done with r1_rdata=0.
REQ-039 Sweep: CLR_PERIOD=300 with no requests -> rc_en high 256 cycles with rc_set 0..255 in order, then IDLE; a request raised mid-sweep is granted the cycle after rc_set=255.
REQ-040 Sweep deferral: period wrap during a stalled ACCESS -> no rc_en until after DONE, then the sweep runs before a waiting request.
REQ-041 Reset mid-access: rst pulsed in the second ACCESS cycle -> no done, all outputs 0 next cycle, next tie granted to r0.

Source files
------------

// File: rtl/cache_port_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cache_port_scheduler
//  Brief    : Two-requester cache port arbiter with a periodic reference-bit
//             clear sweep. Grants one access at a time (round-robin on
//             ties). Every CLR_PERIOD cycles it schedules a sweep that
//             strobes rc_en across all NSETS sets, but only from IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_port_scheduler #(
  parameter int CLR_PERIOD = 1024,
  parameter int NSETS      = 256
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0
  input  logic        r0_req,
  input  logic        r0_op,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_done,
  output logic [31:0] r0_rdata,
  // requester 1
  input  logic        r1_req,
  input  logic        r1_op,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_done,
  output logic [31:0] r1_rdata,
  // cache command / completion
  output logic        c_req,
  output logic        c_op,
  output logic [31:0] c_addr,
  output logic [31:0] c_wdata,
  input  logic        c_ack,
  input  logic [31:0] c_rdata,
  // reference-bit clear sweep
  output logic        rc_en,
  output logic [7:0]  rc_set,
  output logic        busy
);

  localparam logic [15:0] C_CNT_LAST = 16'(CLR_PERIOD - 1);
  localparam logic [7:0]  C_SET_LAST = 8'(NSETS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_SWEEP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_pend;
  logic        r_last;     // port granted most recently (1 = r1)
  logic        r_port;     // port owning the current transaction
  logic        r_r0_gnt, r_r1_gnt, r_r0_done, r_r1_done;
  logic [31:0] r_r0_rdata, r_r1_rdata;
  logic        r_c_req, r_c_op;
  logic [31:0] r_c_addr, r_c_wdata;
  logic        r_rc_en;
  logic [7:0]  r_rc_set;

  logic        w_wrap;
  logic        w_any;
  logic        w_pick;
  logic        w_sel_op;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;

  assign w_wrap      = (r_cnt == C_CNT_LAST);
  assign w_any       = r0_req | r1_req;
  // On a tie the port that was not granted last wins; otherwise the lone requester.
  assign w_pick      = (r0_req & r1_req) ? ~r_last : r1_req;
  assign w_sel_op    = w_pick ? r1_op    : r0_op;
  assign w_sel_addr  = w_pick ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_pick ? r1_wdata : r0_wdata;

  // Free-running sweep period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (w_wrap) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Scheduler FSM with registered outputs; gnt/done are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pend     <= 1'b0;
      r_last     <= 1'b1;  // makes r0 win the first tie
      r_port     <= 1'b0;
      r_r0_gnt   <= 1'b0;
      r_r1_gnt   <= 1'b0;
      r_r0_done  <= 1'b0;
      r_r1_done  <= 1'b0;
      r_r0_rdata <= 32'd0;
      r_r1_rdata <= 32'd0;
      r_c_req    <= 1'b0;
      r_c_op     <= 1'b0;
      r_c_addr   <= 32'd0;
      r_c_wdata  <= 32'd0;
      r_rc_en    <= 1'b0;
      r_rc_set   <= 8'd0;
    end else begin
      r_r0_gnt  <= 1'b0;
      r_r1_gnt  <= 1'b0;
      r_r0_done <= 1'b0;
      r_r1_done <= 1'b0;
      // A wrap while a sweep is already owed or running is dropped.
      if (w_wrap && !r_pend && r_state != S_SWEEP) begin
        r_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_state  <= S_SWEEP;
            r_pend   <= 1'b0;
            r_rc_en  <= 1'b1;
            r_rc_set <= 8'd0;
          end else if (w_any) begin
            r_state   <= S_ACCESS;
            r_port    <= w_pick;
            r_last    <= w_pick;
            r_r0_gnt  <= ~w_pick;
            r_r1_gnt  <= w_pick;
            r_c_req   <= 1'b1;
            r_c_op    <= w_sel_op;
            r_c_addr  <= w_sel_addr;
            r_c_wdata <= w_sel_wdata;
          end
        end
        S_ACCESS: begin
          if (c_ack) begin
            r_state <= S_DONE;
            r_c_req <= 1'b0;
            if (r_port) begin
              r_r1_done  <= 1'b1;
              r_r1_rdata <= r_c_op ? 32'd0 : c_rdata;
            end else begin
              r_r0_done  <= 1'b1;
              r_r0_rdata <= r_c_op ? 32'd0 : c_rdata;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_SWEEP: begin
          if (r_rc_set == C_SET_LAST) begin
            // Sweep complete: the closing edge doubles as the IDLE decision so a
            // request that waited out the sweep is granted straight away.
            r_rc_en  <= 1'b0;
            r_rc_set <= 8'd0;
            if (w_any) begin
              r_state   <= S_ACCESS;
              r_port    <= w_pick;
              r_last    <= w_pick;
              r_r0_gnt  <= ~w_pick;
              r_r1_gnt  <= w_pick;
              r_c_req   <= 1'b1;
              r_c_op    <= w_sel_op;
              r_c_addr  <= w_sel_addr;
              r_c_wdata <= w_sel_wdata;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_rc_set <= r_rc_set + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign r0_gnt   = r_r0_gnt;
  assign r1_gnt   = r_r1_gnt;
  assign r0_done  = r_r0_done;
  assign r1_done  = r_r1_done;
  assign r0_rdata = r_r0_rdata;
  assign r1_rdata = r_r1_rdata;
  assign c_req    = r_c_req;
  assign c_op     = r_c_op;
  assign c_addr   = r_c_addr;
  assign c_wdata  = r_c_wdata;
  assign rc_en    = r_rc_en;
  assign rc_set   = r_rc_set;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_port_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_port_scheduler
//  Brief    : Directed self-checking bench for cache_port_scheduler
//             (CLR_PERIOD=300, NSETS=256).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_port_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_op, r1_req, r1_op;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_done, r1_gnt, r1_done;
  logic [31:0] r0_rdata, r1_rdata;
  logic        c_req, c_op, c_ack;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        rc_en;
  logic [7:0]  rc_set;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  cache_port_scheduler #(.CLR_PERIOD(300), .NSETS(256)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_op(r0_op), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_op(r1_op), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
    .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .rc_en(rc_en), .rc_set(rc_set), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".r0_gnt"},   32'(r0_gnt),   32'd0);
    chk({tag, ".r1_gnt"},   32'(r1_gnt),   32'd0);
    chk({tag, ".r0_done"},  32'(r0_done),  32'd0);
    chk({tag, ".r1_done"},  32'(r1_done),  32'd0);
    chk({tag, ".r0_rdata"}, r0_rdata,      32'd0);
    chk({tag, ".r1_rdata"}, r1_rdata,      32'd0);
    chk({tag, ".c_req"},    32'(c_req),    32'd0);
    chk({tag, ".c_op"},     32'(c_op),     32'd0);
    chk({tag, ".c_addr"},   c_addr,        32'd0);
    chk({tag, ".c_wdata"},  c_wdata,       32'd0);
    chk({tag, ".rc_en"},    32'(rc_en),    32'd0);
    chk({tag, ".rc_set"},   32'(rc_set),   32'd0);
    chk({tag, ".busy"},     32'(busy),     32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 0; r0_op = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_op = 0; r1_addr = 0; r1_wdata = 0;
    c_ack = 0; c_rdata = 0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // ---- contention: alternating grants starting with r0 ----
    r0_req = 1; r1_req = 1; r0_addr = 100; r1_addr = 200; c_ack = 1;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("rr.r0_gnt", 32'(r0_gnt), 32'((g % 2) == 0));
      chk("rr.r1_gnt", 32'(r1_gnt), 32'((g % 2) == 1));
      chk("rr.c_addr", c_addr, ((g % 2) == 0) ? 32'd100 : 32'd200);
      c_rdata = 32'(1000 + g);
      tick();
      chk("rr.r0_done", 32'(r0_done), 32'((g % 2) == 0));
      chk("rr.r1_done", 32'(r1_done), 32'((g % 2) == 1));
      chk("rr.rdata", ((g % 2) == 0) ? r0_rdata : r1_rdata, 32'(1000 + g));
      if (g == 3) begin
        r0_req = 0; r1_req = 0; c_ack = 0;
      end
      tick();
      chk("rr.busy_idle", 32'(busy), 32'd0);
    end

    // ---- single read, ack in first ACCESS cycle ----
    r0_req = 1; r0_op = 0; r0_addr = 64; c_ack = 1; c_rdata = 111;
    tick();
    chk("rd.r0_gnt", 32'(r0_gnt), 32'd1);
    chk("rd.r1_gnt", 32'(r1_gnt), 32'd0);
    chk("rd.c_req",  32'(c_req),  32'd1);
    chk("rd.c_addr", c_addr,      32'd64);
    chk("rd.c_op",   32'(c_op),   32'd0);
    r0_req = 0; r0_addr = 0;
    tick();
    chk("rd.r0_done",  32'(r0_done), 32'd1);
    chk("rd.r0_rdata", r0_rdata,     32'd111);
    chk("rd.r1_done",  32'(r1_done), 32'd0);
    chk("rd.c_req_lo", 32'(c_req),   32'd0);
    c_ack = 0; c_rdata = 0;
    tick();
    chk("rd.busy",       32'(busy),    32'd0);
    chk("rd.done_pulse", 32'(r0_done), 32'd0);
    chk("rd.rdata_hold", r0_rdata,     32'd111);

    // ---- write with slow cache: command held 6 cycles ----
    r1_req = 1; r1_op = 1; r1_addr = 2112; r1_wdata = 5000; c_rdata = 777;
    tick();
    chk("wr.r1_gnt", 32'(r1_gnt), 32'd1);
    r1_req = 0; r1_op = 0; r1_addr = 0; r1_wdata = 0;
    for (int i = 0; i < 6; i++) begin
      chk("wr.c_req",   32'(c_req), 32'd1);
      chk("wr.c_op",    32'(c_op),  32'd1);
      chk("wr.c_addr",  c_addr,     32'd2112);
      chk("wr.c_wdata", c_wdata,    32'd5000);
      if (i == 5) c_ack = 1;
      tick();
    end
    chk("wr.r1_done",  32'(r1_done), 32'd1);
    chk("wr.r1_rdata", r1_rdata,     32'd0);
    chk("wr.c_req_lo", 32'(c_req),   32'd0);
    c_ack = 0;
    tick();
    chk("wr.busy", 32'(busy), 32'd0);

    // ---- ack outside ACCESS is ignored ----
    c_ack = 1;
    tick();
    chk("ack_idle.busy",    32'(busy),    32'd0);
    chk("ack_idle.r0_done", 32'(r0_done), 32'd0);
    chk("ack_idle.r1_done", 32'(r1_done), 32'd0);
    c_ack = 0;

    // ---- sweep timing with a request raised mid-sweep ----
    do_reset();
    repeat (300) tick();
    chk("sw.pre_rc_en", 32'(rc_en), 32'd0);
    chk("sw.pre_busy",  32'(busy),  32'd0);
    tick();
    for (int i = 0; i < 256; i++) begin
      chk("sw.rc_en",  32'(rc_en),  32'd1);
      chk("sw.rc_set", 32'(rc_set), 32'(i));
      chk("sw.c_req",  32'(c_req),  32'd0);
      if (i > 100) chk("sw.no_gnt", 32'(r0_gnt), 32'd0);
      if (i == 100) begin
        r0_req = 1; r0_op = 0; r0_addr = 9;
      end
      tick();
    end
    chk("sw.post_rc_en", 32'(rc_en),  32'd0);
    chk("sw.post_gnt",   32'(r0_gnt), 32'd1);
    chk("sw.post_addr",  c_addr,      32'd9);
    r0_req = 0; c_ack = 1;
    tick();
    chk("sw.done", 32'(r0_done), 32'd1);
    c_ack = 0;
    tick();

    // ---- sweep deferred by a stalled access ----
    do_reset();
    repeat (250) tick();
    r0_req = 1; r0_op = 0; r0_addr = 48;
    tick();
    chk("df.r0_gnt", 32'(r0_gnt), 32'd1);
    r0_req = 0;
    for (int i = 0; i < 80; i++) begin
      chk("df.stall_c_req", 32'(c_req), 32'd1);
      chk("df.stall_rc_en", 32'(rc_en), 32'd0);
      tick();
    end
    r1_req = 1; r1_op = 0; r1_addr = 72; c_ack = 1; c_rdata = 42;
    tick();
    chk("df.r0_done",  32'(r0_done), 32'd1);
    chk("df.r0_rdata", r0_rdata,     32'd42);
    chk("df.done_rc",  32'(rc_en),   32'd0);
    c_ack = 0;
    tick();
    chk("df.idle_busy", 32'(busy),   32'd0);
    chk("df.idle_rc",   32'(rc_en),  32'd0);
    chk("df.idle_gnt",  32'(r1_gnt), 32'd0);
    tick();
    chk("df.sweep_rc_en",  32'(rc_en),  32'd1);
    chk("df.sweep_rc_set", 32'(rc_set), 32'd0);
    chk("df.sweep_no_gnt", 32'(r1_gnt), 32'd0);
    repeat (255) tick();
    chk("df.last_rc_set", 32'(rc_set), 32'd255);
    chk("df.last_rc_en",  32'(rc_en),  32'd1);
    tick();
    chk("df.r1_gnt", 32'(r1_gnt), 32'd1);
    chk("df.c_addr", c_addr,      32'd72);
    chk("df.rc_off", 32'(rc_en),  32'd0);
    r1_req = 0; c_ack = 1;
    tick();
    chk("df.r1_done", 32'(r1_done), 32'd1);
    c_ack = 0;
    tick();

    // ---- reset in the second ACCESS cycle ----
    do_reset();
    r0_req = 1; r0_op = 1; r0_addr = 500; r0_wdata = 3;
    tick();
    chk("rs.r0_gnt", 32'(r0_gnt), 32'd1);
    tick();
    chk("rs.access2_c_req", 32'(c_req), 32'd1);
    rst = 1;
    tick();
    chk_all_zero("rs.after");
    rst = 0;
    r0_op = 0; r1_req = 1; r1_op = 0; r1_addr = 600; c_ack = 1; c_rdata = 5;
    tick();
    chk("rs.tie_r0_gnt", 32'(r0_gnt), 32'd1);
    chk("rs.tie_r1_gnt", 32'(r1_gnt), 32'd0);
    chk("rs.tie_addr",   c_addr,      32'd500);
    r0_req = 0; r1_req = 0;
    tick();
    chk("rs.r0_done", 32'(r0_done), 32'd1);
    chk("rs.r1_done", 32'(r1_done), 32'd0);
    c_ack = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
